pool_flatten: RTL and testbench
===============================

Name: pool_flatten

Overview:
- Layer-1/layer-2 back end of the CONV datapath. Runs after the layer-0 convolution results have been written to the L0 memories.
- Reads the two 64x64 L0 feature maps through the shared crd/csel memory port and applies 2x2 stride-2 max-pooling.
- Writes each pooled value to L1 memory (csel 011/100) and interleaves it into the flatten memory L2 (csel 101).

Parameters:
- DW, 20: data width (Q16.4 feature values).
- AW, 12: memory address width.
- IN_W, 64: input map width/height; output is IN_W/2 square.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin; ignored while busy.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the final L2 write.
- crd  out  1  memory read enable.
- caddr_rd  out  AW  read address.
- cdata_rd  in  DW  read data, valid at the clock edge after crd/caddr_rd are registered.
- cwr  out  1  memory write enable.
- caddr_wr  out  AW  write address.
- cdata_wr  out  DW  write data.
- csel  out  3  memory select: 001 L0 kernel 0, 010 L0 kernel 1, 011 L1 kernel 0, 100 L1 kernel 1, 101 L2, 000 idle.

Behaviour:
- Reset values: busy=0, done=0, crd=0, cwr=0, csel=000, caddr_rd=0, caddr_wr=0, cdata_wr=0, all counters 0, state IDLE. Reset mid-operation aborts immediately; no partial write completes.
- States: IDLE, RD, WAIT, WL1, WL2, FIN.
- IDLE: start=1 -> RD with k=0, r=0, c=0, q=0, busy=1.
- RD (4 cycles, q=0..3):
  - crd=1, csel=001+k.
  - caddr_rd = (2r+q[1])*IN_W + 2c + q[0].
  - In cycles q=1..3, cdata_rd (the value for q-1) is folded into mx; q=1 loads mx directly.
  - After q=3 -> WAIT.
- WAIT: crd=0; fold the final cdata_rd into mx -> WL1.
- WL1: cwr=1, csel=011+k, caddr_wr=r*(IN_W/2)+c, cdata_wr=mx -> WL2.
- WL2: cwr=1, csel=101, caddr_wr=2*(r*(IN_W/2)+c)+k, cdata_wr=mx. Then advance:
  - c wraps at IN_W/2-1, carrying into r.
  - r wraps at IN_W/2-1, carrying into k.
  - After k=1, r=31, c=31 -> FIN; otherwise -> RD.
- FIN: done=1, busy=0 -> IDLE.
- Port exclusivity: crd and cwr are never high in the same cycle; csel=000 whenever both are low.
- Compare: unsigned DW-bit magnitude; ties keep the earlier value. The output is exactly one of the four inputs, with no rounding.
- Latency: 7 cycles per pooled pixel; full run = 2*1024*7 + 2 = 14338 cycles from the start edge to the done pulse.
- start asserted during busy or FIN is ignored.

Optional Feature:
- Macro: POOL_RELU_EN.
- Defined: inputs are compared as signed two's complement, and a negative pooled maximum is clamped to 0 before both writes (ReLU fused, for L0 data stored pre-activation).
- Undefined: unsigned compare, no clamp.

Decomposition:
- Shared package cnn_pkg:
  - DW/AW constants.
  - csel encodings (CSEL_IDLE, CSEL_L0K0, CSEL_L0K1, CSEL_L1K0, CSEL_L1K1, CSEL_L2).
  - FSM state enum.
- One sub-module, pool_max4: sequential accumulator with clear/load/fold inputs. It holds mx and contains the compare, including the POOL_RELU_EN signed/clamp variant.
- Address generation and the FSM stay in pool_flatten.

Test Plan:
- Ramp check: L0 k0 = address value (0..4095), L0 k1 = 0. Required:
  - L1 k0[0] = 0x00041 and L1 k0[1023] = 0x00FFF.
  - L2[0] = 0x00041 and L2[1] = 0.
  - done exactly 14338 cycles after start.
- Tie/order check: window at address 0 = {5,5,3,5}. Required: L1 k0[0] = 5 and exactly one L1 write to address 0.
- Large-value check: L0 k1 window 0 = {0x80000, 0x00010, 0, 0}. Required:
  - Without POOL_RELU_EN: 0x80000 at L1 k1[0] and L2[1].
  - With POOL_RELU_EN: 0x00010.
- Reset mid-run: drive reset low at cycle 500. Required:
  - The same cycle: busy=0, crd=0, cwr=0, csel=000.
  - After release plus start, the full correct output is produced.
- Protocol monitor, over the whole run:
  - Never crd&cwr together.
  - csel=000 whenever both crd and cwr are low.
  - start pulsed at cycle 100 while busy causes no restart (L2 write count stays 2048).

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: constants shared by the CONV back-end blocks.
//   CNN_DW / CNN_AW - default data and address widths (Q16.4 data, 4K-word memories).
//   CSEL_*          - memory select encodings for the shared crd/cwr port.
//   pool_state_t    - pool_flatten FSM states.
package cnn_pkg;

  localparam int CNN_DW = 20;
  localparam int CNN_AW = 12;

  localparam logic [2:0] CSEL_IDLE = 3'b000;
  localparam logic [2:0] CSEL_L0K0 = 3'b001;
  localparam logic [2:0] CSEL_L0K1 = 3'b010;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WL1,
    ST_WL2,
    ST_FIN
  } pool_state_t;

endpackage

// File: rtl/pool_max4.sv
// pool_max4: running-maximum accumulator for one 2x2 pooling window.
//   clk, reset (async, active low)
//   clear - zero the accumulator
//   load  - take din unconditionally (first element of a window)
//   fold  - take din only if strictly greater (ties keep the earlier value)
//   din   - candidate value
//   mx    - current maximum
// Build option POOL_RELU_EN: compare as signed two's complement and clamp a
// negative maximum to zero on the output. Without it the compare is unsigned.
module pool_max4
  import cnn_pkg::*;
#(
  parameter int DW = CNN_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic          fold,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] mx
);

  logic [DW-1:0] acc;
  logic          take;

`ifdef POOL_RELU_EN
  assign take = $signed(din) > $signed(acc);
  // Clamp is applied on the way out so the compare still sees the true max.
  assign mx   = acc[DW-1] ? '0 : acc;
`else
  assign take = din > acc;
  assign mx   = acc;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (load) begin
      acc <= din;
    end else if (fold && take) begin
      acc <= din;
    end
  end

endmodule

// File: rtl/pool_flatten.sv
// pool_flatten: 2x2 stride-2 max-pool of both L0 feature maps, writing each
// pooled value to L1 (per kernel) and interleaved into the flatten memory L2.
//   clk, reset (async, active low)
//   start            - one-cycle request, ignored while busy
//   busy, done       - run status; done pulses once after the last L2 write
//   crd, caddr_rd    - memory read request (data returns one cycle later)
//   cdata_rd         - read data
//   cwr, caddr_wr,
//   cdata_wr         - memory write request
//   csel             - memory select (cnn_pkg CSEL_*)
// Build option POOL_RELU_EN (in pool_max4): signed compare with ReLU clamp.
//
// Outputs are decoded from the registered state and counters, so an
// asynchronous reset drops crd/cwr/csel in the same cycle.
module pool_flatten
  import cnn_pkg::*;
#(
  parameter int DW   = CNN_DW,
  parameter int AW   = CNN_AW,
  parameter int IN_W = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int HALF = IN_W / 2;
  localparam int CW   = $clog2(HALF);
  localparam logic [CW-1:0] LAST   = CW'(HALF - 1);
  localparam logic [AW-1:0] HALF_A = AW'(HALF);
  localparam logic [AW-1:0] IN_A   = AW'(IN_W);

  pool_state_t   state, state_nx;
  logic [CW-1:0] r, c;
  logic          k;
  logic [1:0]    q;
  logic          last_col, last_row, last_pix;
  logic          acc_clear, acc_load, acc_fold;
  logic [DW-1:0] mx;
  logic [AW-1:0] pix_addr, rd_row, rd_col;

  assign last_col = (c == LAST);
  assign last_row = (r == LAST);
  assign last_pix = k & last_row & last_col;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RD;
      ST_RD:   if (q == 2'd3) state_nx = ST_WAIT;
      ST_WAIT: state_nx = ST_WL1;
      ST_WL1:  state_nx = ST_WL2;
      ST_WL2:  state_nx = last_pix ? ST_FIN : ST_RD;
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Window position: k selects the map, (r, c) the pooled pixel, q the
  // element inside the 2x2 window. c carries into r, r carries into k.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k <= 1'b0;
      r <= '0;
      c <= '0;
      q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            k <= 1'b0;
            r <= '0;
            c <= '0;
            q <= '0;
          end
        end
        ST_RD: q <= q + 2'd1;
        ST_WL2: begin
          if (last_col) begin
            c <= '0;
            if (last_row) begin
              r <= '0;
              k <= ~k;
            end else begin
              r <= r + 1'b1;
            end
          end else begin
            c <= c + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read data lags the address by one cycle: RD q=1 sees element 0 (load),
  // RD q=2..3 and WAIT see elements 1..3 (fold).
  assign acc_clear = (state == ST_IDLE) && start;
  assign acc_load  = (state == ST_RD) && (q == 2'd1);
  assign acc_fold  = ((state == ST_RD) && (q[1] == 1'b1)) || (state == ST_WAIT);

  pool_max4 #(.DW(DW)) u_max4 (
    .clk   (clk),
    .reset (reset),
    .clear (acc_clear),
    .load  (acc_load),
    .fold  (acc_fold),
    .din   (cdata_rd),
    .mx    (mx)
  );

  // {r, q[1]} = 2r + q[1];  {c, q[0]} = 2c + q[0]
  assign rd_row   = AW'({r, q[1]});
  assign rd_col   = AW'({c, q[0]});
  assign pix_addr = AW'(r) * HALF_A + AW'(c);

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    crd      = 1'b0;
    caddr_rd = '0;
    cwr      = 1'b0;
    caddr_wr = '0;
    cdata_wr = '0;
    csel     = CSEL_IDLE;
    case (state)
      ST_RD: begin
        busy     = 1'b1;
        crd      = 1'b1;
        csel     = k ? CSEL_L0K1 : CSEL_L0K0;
        caddr_rd = rd_row * IN_A + rd_col;
      end
      ST_WAIT: busy = 1'b1;
      ST_WL1: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = k ? CSEL_L1K1 : CSEL_L1K0;
        caddr_wr = pix_addr;
        cdata_wr = mx;
      end
      ST_WL2: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = CSEL_L2;
        caddr_wr = AW'({pix_addr, k});
        cdata_wr = mx;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pool_flatten.sv
module tb_pool_flatten;

  localparam int DW = 20;
  localparam int AW = 12;
  localparam int RUN_LAT = 14338;

`ifdef POOL_RELU_EN
  localparam logic [DW-1:0] EXP_BIG = 20'h00010;
`else
  localparam logic [DW-1:0] EXP_BIG = 20'h80000;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done, crd, cwr;
  logic [AW-1:0] caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;
  logic [2:0]    csel;

  pool_flatten dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // L0 memories with one-cycle registered read.
  logic [DW-1:0] mem0 [4096];
  logic [DW-1:0] mem1 [4096];

  initial cdata_rd = '0;
  always @(posedge clk) begin
    if (crd) cdata_rd <= (csel == 3'b001) ? mem0[caddr_rd] : mem1[caddr_rd];
  end

  // Write logs.
  logic [DW-1:0] l1k0 [1024];
  logic [DW-1:0] l1k1 [1024];
  logic [DW-1:0] l2   [2048];
  int l1k0_a0_wr, l2_wr;

  task automatic clear_logs();
    for (int i = 0; i < 1024; i++) begin l1k0[i] = 'x; l1k1[i] = 'x; end
    for (int i = 0; i < 2048; i++) l2[i] = 'x;
    l1k0_a0_wr = 0;
    l2_wr = 0;
  endtask

  // Reference model: full list of writes the run must produce, in order.
  typedef struct {
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  function automatic int val(input logic [DW-1:0] x);
`ifdef POOL_RELU_EN
    return int'($signed(x));
`else
    return int'(x);
`endif
  endfunction

  function automatic logic [DW-1:0] pool4(input logic [DW-1:0] a, b, c, d);
    logic [DW-1:0] w[4];
    int best;
    w = '{a, b, c, d};
    best = val(w[0]);
    for (int i = 1; i < 4; i++) if (val(w[i]) > best) best = val(w[i]);
`ifdef POOL_RELU_EN
    if (best < 0) best = 0;
`endif
    return DW'(best);
  endfunction

  task automatic build_expect();
    wr_t e;
    logic [DW-1:0] v;
    int base;
    exp_q.delete();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++) begin
          base = 2 * r * 64 + 2 * c;
          if (k == 0) v = pool4(mem0[base], mem0[base + 1], mem0[base + 64], mem0[base + 65]);
          else        v = pool4(mem1[base], mem1[base + 1], mem1[base + 64], mem1[base + 65]);
          e.sel = (k == 0) ? 3'b011 : 3'b100; e.addr = AW'(r * 32 + c); e.data = v;
          exp_q.push_back(e);
          e.sel = 3'b101; e.addr = AW'(2 * (r * 32 + c) + k);
          exp_q.push_back(e);
        end
  endtask

  // Compare process: protocol every cycle, each write against the model.
  always @(negedge clk) begin
    wr_t e;
    if (reset === 1'b1) begin
      chk("port_excl", 32'(crd & cwr), 32'd0);
      if (!crd && !cwr) chk("idle_csel", 32'(csel), 32'd0);
      if (cwr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(caddr_wr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_sel", 32'(csel), 32'(e.sel));
          chk("wr_addr", 32'(caddr_wr), 32'(e.addr));
          chk("wr_data", 32'(cdata_wr), 32'(e.data));
        end
        case (csel)
          3'b011: begin l1k0[caddr_wr[9:0]] = cdata_wr; if (caddr_wr == 0) l1k0_a0_wr++; end
          3'b100: l1k1[caddr_wr[9:0]] = cdata_wr;
          3'b101: begin l2[caddr_wr[10:0]] = cdata_wr; l2_wr++; end
          default: ;
        endcase
      end
    end
  end

  task automatic run(input bit poke, input int abort_at, output int lat);
    int s;
    bit aborted;
    lat = -1;
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 20000; i++) begin
      if (done) begin lat = cyc - s + 1; break; end
      start = (poke && (cyc - s == 100)) ? 1'b1 : 1'b0;
      if (abort_at > 0 && (cyc - s == abort_at)) begin
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_crd", 32'(crd), 32'd0);
        chk("rst_cwr", 32'(cwr), 32'd0);
        chk("rst_csel", 32'(csel), 32'd0);
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!aborted) begin
      chk("latency", 32'(lat), 32'(RUN_LAT));
      chk("busy_at_done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
    end
  endtask

  int lat;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    clear_logs();
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_crd", 32'(crd), 32'd0);
    chk("reset_cwr", 32'(cwr), 32'd0);
    chk("reset_csel", 32'(csel), 32'd0);
    chk("reset_addr", 32'({caddr_rd, caddr_wr}), 32'd0);
    chk("reset_wdata", 32'(cdata_wr), 32'd0);
    reset = 1'b1;

    // Ramp: k0 = address, k1 = 0; start poked mid-run must be ignored.
    for (int i = 0; i < 4096; i++) begin mem0[i] = DW'(i); mem1[i] = '0; end
    build_expect();
    chk("model_ramp_first", 32'(exp_q[0].data), 32'h41);
    clear_logs();
    run(1'b1, 0, lat);
    chk("ramp_l1k0_0", 32'(l1k0[0]), 32'h00041);
    chk("ramp_l1k0_1023", 32'(l1k0[1023]), 32'h00FFF);
    chk("ramp_l2_0", 32'(l2[0]), 32'h00041);
    chk("ramp_l2_1", 32'(l2[1]), 32'h0);
    chk("ramp_l2_count", 32'(l2_wr), 32'd2048);
    chk("ramp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random data with the tie window and the large-value window.
    for (int i = 0; i < 4096; i++) begin mem0[i] = DW'($urandom()); mem1[i] = DW'($urandom()); end
    mem0[0] = 20'd5; mem0[1] = 20'd5; mem0[64] = 20'd3; mem0[65] = 20'd5;
    mem1[0] = 20'h80000; mem1[1] = 20'h00010; mem1[64] = '0; mem1[65] = '0;
    build_expect();
    chk("model_tie", 32'(exp_q[0].data), 32'd5);
    clear_logs();
    run(1'b0, 0, lat);
    chk("tie_l1k0_0", 32'(l1k0[0]), 32'd5);
    chk("tie_single_write", 32'(l1k0_a0_wr), 32'd1);
    chk("big_l1k1_0", 32'(l1k1[0]), 32'(EXP_BIG));
    chk("big_l2_1", 32'(l2[1]), 32'(EXP_BIG));
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-run, then a full clean run.
    for (int i = 0; i < 4096; i++) begin mem0[i] = DW'($urandom()); mem1[i] = DW'($urandom()); end
    build_expect();
    clear_logs();
    run(1'b0, 500, lat);
    exp_q.delete();
    @(negedge clk);
    chk("rst_held_cwr", 32'(cwr), 32'd0);
    reset = 1'b1;
    build_expect();
    clear_logs();
    run(1'b0, 0, lat);
    chk("rerun_l2_count", 32'(l2_wr), 32'd2048);
    chk("rerun_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
